// File: rtl/pwm_multi_gen_if.sv
// Control/status bundle for pwm_multi_gen: the register side drives the
// master modport, the generator sits on the slave modport.
interface pwm_multi_gen_if #(
   parameter int WIDTH    = 8,
   parameter int CHANNELS = 4
);
   logic                        enable;
   logic                        load;
   logic [WIDTH-1:0]            period_in;
   logic                        mode_in;
   logic [CHANNELS*WIDTH-1:0]   duty_in;
   logic [CHANNELS-1:0]         pwm;
   logic                        period_start;
   logic                        update_pending;
   logic [WIDTH-1:0]            counter;

   modport master (
      output enable, load, period_in, mode_in, duty_in,
      input  pwm, period_start, update_pending, counter
   );

   modport slave (
      input  enable, load, period_in, mode_in, duty_in,
      output pwm, period_start, update_pending, counter
   );
endinterface

// File: rtl/pwm_multi_gen.sv
// Multi-channel PWM generator: one shared timebase (edge or center aligned),
// double-buffered period/mode/duty that switch only at a period boundary.
module pwm_multi_gen #(
   parameter int WIDTH    = 8,
   parameter int CHANNELS = 4
) (
   input logic              clk,
   input logic              rst_n,
   pwm_multi_gen_if.slave   bus
);

   typedef enum logic {
      DIR_UP   = 1'b0,
      DIR_DOWN = 1'b1
   } dir_e;

   logic [WIDTH-1:0]                 cnt_q, cnt_d;
   dir_e                             dir_q, dir_d;
   logic [WIDTH-1:0]                 act_p_q, act_p_d;
   logic [WIDTH-1:0]                 shd_p_q, shd_p_d;
   logic                             act_mode_q, act_mode_d;
   logic                             shd_mode_q, shd_mode_d;
   logic [CHANNELS-1:0][WIDTH-1:0]   act_duty_q, act_duty_d;
   logic [CHANNELS-1:0][WIDTH-1:0]   shd_duty_q, shd_duty_d;
   logic                             pend_q, pend_d;
   logic [CHANNELS-1:0]              pwm_q, pwm_d;
   logic                             pstart_q, pstart_d;

   logic [WIDTH-1:0]                 p_eff;
   logic                             boundary;

   always_comb begin
      // Center mode treats P=0 as P=1 so the up/down walk always has a top.
      p_eff    = (act_p_q == '0) ? {{(WIDTH-1){1'b0}}, 1'b1} : act_p_q;
      boundary = act_mode_q ? ((cnt_q == '0) && (dir_q == DIR_DOWN))
                            : (cnt_q >= act_p_q);

      cnt_d      = cnt_q;
      dir_d      = dir_q;
      act_p_d    = act_p_q;
      shd_p_d    = shd_p_q;
      act_mode_d = act_mode_q;
      shd_mode_d = shd_mode_q;
      act_duty_d = act_duty_q;
      shd_duty_d = shd_duty_q;
      pend_d     = pend_q;
      pwm_d      = pwm_q;
      pstart_d   = pstart_q;

      if (!bus.enable) begin
         cnt_d    = '0;
         dir_d    = DIR_UP;
         pwm_d    = '0;
         pstart_d = 1'b0;
         if (bus.load) begin
            act_p_d    = bus.period_in;
            act_mode_d = bus.mode_in;
            act_duty_d = bus.duty_in;
            shd_p_d    = bus.period_in;
            shd_mode_d = bus.mode_in;
            shd_duty_d = bus.duty_in;
            pend_d     = 1'b0;
         end
      end else begin
         for (int i = 0; i < CHANNELS; i++) begin
            pwm_d[i] = (cnt_q < act_duty_q[i]);
         end
         pstart_d = (cnt_q == '0) && (dir_q == DIR_UP);

         // A load landing on the boundary edge bypasses the shadow stage.
         if (bus.load) begin
            shd_p_d    = bus.period_in;
            shd_mode_d = bus.mode_in;
            shd_duty_d = bus.duty_in;
            if (boundary) begin
               act_p_d    = bus.period_in;
               act_mode_d = bus.mode_in;
               act_duty_d = bus.duty_in;
               pend_d     = 1'b0;
            end else begin
               pend_d     = 1'b1;
            end
         end else if (boundary && pend_q) begin
            act_p_d    = shd_p_q;
            act_mode_d = shd_mode_q;
            act_duty_d = shd_duty_q;
            pend_d     = 1'b0;
         end

         if (boundary) begin
            cnt_d = '0;
            dir_d = DIR_UP;
         end else if (!act_mode_q) begin
            cnt_d = cnt_q + 1'b1;
         end else if (dir_q == DIR_UP) begin
            if (cnt_q >= p_eff - 1'b1) begin
               dir_d = DIR_DOWN;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end else begin
            cnt_d = cnt_q - 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q      <= '0;
         dir_q      <= DIR_UP;
         act_p_q    <= '0;
         shd_p_q    <= '0;
         act_mode_q <= 1'b0;
         shd_mode_q <= 1'b0;
         act_duty_q <= '0;
         shd_duty_q <= '0;
         pend_q     <= 1'b0;
         pwm_q      <= '0;
         pstart_q   <= 1'b0;
      end else begin
         cnt_q      <= cnt_d;
         dir_q      <= dir_d;
         act_p_q    <= act_p_d;
         shd_p_q    <= shd_p_d;
         act_mode_q <= act_mode_d;
         shd_mode_q <= shd_mode_d;
         act_duty_q <= act_duty_d;
         shd_duty_q <= shd_duty_d;
         pend_q     <= pend_d;
         pwm_q      <= pwm_d;
         pstart_q   <= pstart_d;
      end
   end

   assign bus.pwm            = pwm_q;
   assign bus.period_start   = pstart_q;
   assign bus.update_pending = pend_q;
   assign bus.counter        = cnt_q;

endmodule
